switch_reader: RTL and testbench



---
 rtl/switch_reader.sv | 110 +++++++++++
 tb/tb_switch_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
// Debounced, synchronized slide-switch reader with change events on a valid/ready handshake.
// Each bit is synchronized, filtered independently, and changes are published as coalesced events.
module switch_reader #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] stable_o,
  output logic             event_valid_o,
  output logic [WIDTH-1:0] event_data_o,
  input  logic             event_ready_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] last_sent_q, last_sent_d;
  logic [WIDTH-1:0] ev_data_q, ev_data_d;
  logic             ev_valid_q, ev_valid_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Two-flop synchronizer per bit
  always_comb begin
    sync1_d = switches;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: any return to the accepted value restarts the count
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event generation; a stalled event is refreshed with the latest value on handshake
  always_comb begin
    ev_valid_d  = ev_valid_q;
    ev_data_d   = ev_data_q;
    last_sent_d = last_sent_q;
    if (!ev_valid_q || event_ready_i) begin
      if (stable_q != last_sent_q) begin
        ev_valid_d  = 1'b1;
        ev_data_d   = stable_q;
        last_sent_d = stable_q;
      end else begin
        ev_valid_d  = 1'b0;
      end
    end
  end

  // Sticky overrun: set has priority over clear
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    if ((stable_d != stable_q) && ev_valid_q && !event_ready_i) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      last_sent_q <= '0;
      ev_data_q   <= '0;
      ev_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      last_sent_q <= last_sent_d;
      ev_data_q   <= ev_data_d;
      ev_valid_q  <= ev_valid_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o      = stable_q;
  assign event_valid_o = ev_valid_q;
  assign event_data_o  = ev_data_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_switch_reader.sv
// Directed and randomized bench for switch_reader against a history-based reference model.
module tb_switch_reader;

  localparam int unsigned W  = 4;
  localparam int unsigned SC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] switches;
  logic [W-1:0] stable_o;
  logic         event_valid_o;
  logic [W-1:0] event_data_o;
  logic         event_ready_i;
  logic         overrun_o;
  logic         overrun_clr_i;

  int checks = 0;
  int errors = 0;

  switch_reader #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .switches      (switches),
    .stable_o      (stable_o),
    .event_valid_o (event_valid_o),
    .event_data_o  (event_data_o),
    .event_ready_i (event_ready_i),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i)
  );

  always #5 clk = ~clk;

  // Reference model: a bit flips once its last SC synchronized samples all disagree with it
  logic [W-1:0] m_sw1, m_sw2, m_stable, m_data, m_last;
  logic         m_valid, m_ovr;
  logic [W-1:0] hist [$];

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_stable = '0; m_data = '0; m_last = '0;
    m_valid = 1'b0; m_ovr = 1'b0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] ns;
    logic         all_diff;
    ns = m_stable;
    hist.push_back(m_sw2);
    if (hist.size() > SC) void'(hist.pop_front());
    for (int i = 0; i < int'(W); i++) begin
      all_diff = (hist.size() == SC);
      foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) ns[i] = ~m_stable[i];
    end
    if (overrun_clr_i) m_ovr = 1'b0;
    if ((ns != m_stable) && m_valid && !event_ready_i) m_ovr = 1'b1;
    if (!m_valid || event_ready_i) begin
      if (m_stable != m_last) begin
        m_valid = 1'b1; m_data = m_stable; m_last = m_stable;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_stable = ns;
    m_sw2 = m_sw1;
    m_sw1 = switches;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".stable"},  32'(stable_o),      32'(m_stable));
    chk({tag, ".valid"},   32'(event_valid_o), 32'(m_valid));
    if (m_valid) chk({tag, ".data"}, 32'(event_data_o), 32'(m_data));
    chk({tag, ".overrun"}, 32'(overrun_o),     32'(m_ovr));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic settle(input logic [W-1:0] v, input string tag);
    switches = v;
    event_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) tick(tag);
  endtask

  int vcount;
  int hold;

  initial begin
    rst_n = 1'b0; switches = '0; event_ready_i = 1'b1; overrun_clr_i = 1'b0;
    model_reset();
    #1;
    chk("reset.stable", 32'(stable_o), 32'h0);
    chk("reset.valid", 32'(event_valid_o), 32'h0);
    chk("reset.overrun", 32'(overrun_o), 32'h0);
    for (int k = 0; k < 3; k++) tick("in_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick("idle");
      chk("idle.stable", 32'(stable_o), 32'h0);
      chk("idle.valid", 32'(event_valid_o), 32'h0);
    end

    // Basic latency: stable at edge SC+2, event at SC+3 for one cycle
    switches = 4'b0101;
    for (int e = 1; e <= 8; e++) begin
      tick("lat");
      if (e == 5) chk("lat.stable_e5", 32'(stable_o), 32'h0);
      if (e == 6) chk("lat.stable_e6", 32'(stable_o), 32'h5);
      if (e == 6) chk("lat.valid_e6", 32'(event_valid_o), 32'h0);
      if (e == 7) chk("lat.valid_e7", 32'(event_valid_o), 32'h1);
      if (e == 7) chk("lat.data_e7", 32'(event_data_o), 32'h5);
      if (e == 8) chk("lat.valid_e8", 32'(event_valid_o), 32'h0);
    end
    settle(4'b0000, "back0");

    // Short bounce rejected
    switches = 4'b0001;
    vcount = 0;
    for (int k = 0; k < 3; k++) begin tick("bounce"); vcount += int'(event_valid_o); end
    switches = 4'b0000;
    for (int k = 0; k < 10; k++) begin tick("bounce"); vcount += int'(event_valid_o); end
    chk("bounce.stable", 32'(stable_o), 32'h0);
    chk("bounce.events", 32'(vcount), 32'd0);

    // Pulse long enough is accepted once
    switches = 4'b0001;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin tick("pulse"); vcount += int'(event_valid_o); end
    switches = 4'b0000;
    for (int k = 0; k < 2; k++) begin tick("pulse"); vcount += int'(event_valid_o); end
    chk("pulse.stable", 32'(stable_o[0]), 32'h1);
    chk("pulse.events", 32'(vcount), 32'd1);
    settle(4'b0000, "back0b");

    // Stall, coalescing and overrun
    event_ready_i = 1'b0;
    switches = 4'b0001;
    for (int k = 0; k < 8; k++) tick("stall1");
    chk("stall.valid", 32'(event_valid_o), 32'h1);
    chk("stall.data1", 32'(event_data_o), 32'h1);
    switches = 4'b0011;
    for (int k = 0; k < 8; k++) tick("stall2");
    chk("stall.data_held", 32'(event_data_o), 32'h1);
    chk("stall.overrun", 32'(overrun_o), 32'h1);
    event_ready_i = 1'b1;
    tick("hs1");
    event_ready_i = 1'b0;
    chk("hs1.valid", 32'(event_valid_o), 32'h1);
    chk("hs1.data", 32'(event_data_o), 32'h3);
    tick("hs1_hold");
    event_ready_i = 1'b1;
    tick("hs2");
    chk("hs2.valid", 32'(event_valid_o), 32'h0);
    chk("hs2.overrun_sticky", 32'(overrun_o), 32'h1);
    overrun_clr_i = 1'b1;
    tick("clr");
    overrun_clr_i = 1'b0;
    chk("clr.overrun", 32'(overrun_o), 32'h0);
    settle(4'b0000, "back0c");

    // All bits together give a single event
    switches = 4'b1111;
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick("all");
      if (event_valid_o) begin
        vcount++;
        chk("all.data", 32'(event_data_o), 32'hF);
      end
    end
    chk("all.events", 32'(vcount), 32'd1);
    settle(4'b0000, "back0d");

    // Reset mid-count, then re-debounce from scratch
    switches = 4'b1000;
    vcount = 0;
    for (int k = 0; k < 4; k++) begin tick("rst_pre"); vcount += int'(event_valid_o); end
    chk("rst_pre.events", 32'(vcount), 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async.stable", 32'(stable_o), 32'h0);
    chk("rst_async.valid", 32'(event_valid_o), 32'h0);
    tick("rst_hold");
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick("rst_post");
      if (e == 5) chk("rst_post.stable_e5", 32'(stable_o), 32'h0);
      if (e == 6) chk("rst_post.stable_e6", 32'(stable_o), 32'h8);
    end
    tick("rst_evt");
    chk("rst_evt.valid", 32'(event_valid_o), 32'h1);
    chk("rst_evt.data", 32'(event_data_o), 32'h8);

    // Randomized bouncing inputs, ready stalls and clears
    hold = 0;
    for (int k = 0; k < 2000; k++) begin
      if (hold == 0) begin
        switches = W'($urandom);
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      event_ready_i = ($urandom % 4) != 0;
      overrun_clr_i = ($urandom % 16) == 0;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
